uart_tx_frame: RTL
==================

# uart_tx_frame

Serializing UART transmitter for the system's transmit path, the sending end of the oversampled UART link.
- Accepts a parallel data word with a valid strobe.
- Emits start bit, data LSB-first, optional parity and one stop bit on `TX_OUT`.
- Holds every bit for `prescale` clock cycles, matching the receiver's oversampling ratio.
- Reports `busy` to the upstream data source (register file/ALU result path) for flow control.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: data word width in bits.

Ports:
- `CLK`  in  1: transmit clock; all logic is on its rising edge.
- `RST`  in  1: reset, synchronous, active-low.
- `P_DATA`  in  DATA_WIDTH: parallel word to send.
- `Data_Valid`  in  1: request strobe; qualifies `P_DATA`.
- `PAR_EN`  in  1: 1 means the frame includes a parity bit.
- `PAR_TYP`  in  1: 0 means even parity, 1 means odd parity.
- `prescale`  in  6: clock cycles per bit; values 0 and 1 both mean 1 cycle per bit.
- `TX_OUT`  out  1: serial line, registered, idles high.
- `busy`  out  1: registered; high while a frame is in progress.

## Operation

- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance:** `Data_Valid` is sampled only in IDLE, or in the last cycle of STOP. On acceptance the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale`, and computes the parity bit from the latched word. The next state is START.
- **Ignored inputs:** `Data_Valid` and all other inputs are ignored in every other state/cycle. No error is flagged.
- **Edge counter:** 6-bit counter `0..prescale_lat-1`. It resets to 0 on every bit boundary and on acceptance. A bit ends when the count equals `prescale_lat-1`.
- **Bit counter:** counts data bits `0..DATA_WIDTH-1`.
- **Per-state behaviour:**
  - IDLE: `TX_OUT`=1, `busy`=0.
  - START: `TX_OUT`=0 for one bit period, then DATA.
  - DATA: `TX_OUT`=`data_lat[bit_cnt]`, LSB first. After bit `DATA_WIDTH-1`, go to PARITY if the latched `PAR_EN` is 1, else to STOP.
  - PARITY: `TX_OUT` = XOR of the data bits, inverted when `PAR_TYP`=1.
  - STOP: `TX_OUT`=1 for one bit period. At its last cycle, go to START if `Data_Valid`=1 (back-to-back frame, no idle gap, `busy` stays high), else to IDLE.
- **Busy:** `busy` = (state != IDLE), registered.
- **Mid-frame input changes:** changes to `P_DATA`, `PAR_*` or `prescale` during a frame have no effect on it.
- **Reset:** a clock edge with `RST`=0 forces IDLE, `TX_OUT`=1, `busy`=0 and clears both counters, including mid-frame. The partial frame is abandoned. `Data_Valid` on that edge is ignored.

## Timing

- **Reset values:** `TX_OUT`=1, `busy`=0.
- **Latency:** `Data_Valid` accepted at edge k, so `TX_OUT` falls and `busy` rises after edge k+1.
- **Frame length:** `P`×(`DATA_WIDTH`+2+`PAR_EN`) cycles, where `P`=max(`prescale`,1).
- **Busy release:** `busy` falls one cycle after the last STOP cycle.
- **Back-to-back framing:** consecutive frames are contiguous. The next start bit directly follows the last stop cycle.
- **Outputs:** all are glitch-free flop outputs.

## Configuration

- **`UART_TX_PARITY_EN` defined:**
  - PARITY state and parity generator are present.
  - `PAR_EN`/`PAR_TYP` behave as above.
- **`UART_TX_PARITY_EN` undefined:**
  - The PARITY state and generator are not built.
  - `PAR_EN`/`PAR_TYP` ports remain but are ignored.
  - Every frame is `DATA_WIDTH`+2 bits.

## Test plan

- `RST`=0 for 2 cycles with `Data_Valid`=1 → `TX_OUT`=1, `busy`=0 throughout; no frame is sent after release until a new strobe.
- `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0, `prescale`=8 → line sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop), each 8 cycles; `busy` high for exactly 88 cycles.
- `P_DATA`=8'h03, `PAR_EN`=1, `PAR_TYP`=1, `prescale`=4 → parity bit 1; total frame length 44 cycles.
- `P_DATA`=8'h3C, `PAR_EN`=0, `prescale`=1 → 10-cycle frame 0,0,0,1,1,1,1,0,0,1. `P_DATA` changed mid-frame does not alter the output.
- Two words 8'h55 then 8'hF0, `PAR_EN`=0, `prescale`=8, second strobe in the last STOP cycle → second start bit immediately follows the stop; `busy` stays high for 160 cycles. A strobe mid-frame is ignored.
- `RST` low at cycle 30 of a frame → `TX_OUT`=1 and `busy`=0 after that edge. A new strobe after release sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Parity generation is built only when UART_TX_PARITY_EN is defined; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [5:0]            plat_q, plat_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;
  logic                  accept;

`ifdef UART_TX_PARITY_EN
  logic                  pen_q, pen_d;
  logic                  par_q, par_d;
`else
  logic                  unused_par;
  assign unused_par = ^{PAR_EN, PAR_TYP};
`endif

  assign bit_end = (cnt_q == plat_q - 6'd1);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    plat_d  = plat_q;
    accept  = 1'b0;
`ifdef UART_TX_PARITY_EN
    pen_d   = pen_q;
    par_d   = par_q;
`endif
    case (state_q)
      IDLE:  accept = Data_Valid;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = pen_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        // A strobe in the final stop cycle chains the next frame with no idle gap.
        if (bit_end) begin
          if (Data_Valid) accept = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = (state_q == IDLE || bit_end) ? 6'd0 : cnt_q + 6'd1;

    if (accept) begin
      state_d = START;
      cnt_d   = 6'd0;
      data_d  = P_DATA;
      plat_d  = (prescale == 6'd0) ? 6'd1 : prescale;
`ifdef UART_TX_PARITY_EN
      pen_d   = PAR_EN;
      par_d   = (^P_DATA) ^ PAR_TYP;
`endif
    end
  end

  // Line and busy are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    case (state_q)
      START:  tx_d = 1'b0;
      DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge CLK) begin
    data_q <= data_d;
    plat_q <= plat_d;
`ifdef UART_TX_PARITY_EN
    pen_q  <= pen_d;
    par_q  <= par_d;
`endif
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
